neurosync_play_responder: RTL and testbench
===========================================

// Module: neurosync_play_responder
// PURPOSE
//  Responder side of the "play" handshake consumed by the game control unit.
//  Executes two request types:
//   - timed servo/indicator move; pronto_play rises when the move finishes.
//   - answer capture: waits for a button press, compares it with the expected
//     answer, reports acertou_play together with pronto_play.
//  Sits between the control unit and the button/servo datapath.
// PARAMETERS
//  MOVE_TICKS   50_000_000  clock cycles a move takes before pronto_play rises
//  TIMEOUT      0           answer-wait timeout in cycles; 0 = no timeout
//  CNT_W        26          counter width; must hold max(MOVE_TICKS, TIMEOUT)
// PORTS
//  clock           in   1  system clock, rising edge
//  reset           in   1  synchronous, active-high
//  req_move        in   1  1-cycle pulse: start a timed move
//  req_resposta    in   1  1-cycle pulse: start answer capture
//  resposta_esp    in   4  expected answer, one-hot; sampled on req_resposta
//  botoes          in   4  debounced buttons, level, active-high
//  pronto_play     out  1  request finished (semantics per state, below)
//  acertou_play    out  1  last captured answer matched
//  ocupado         out  1  move or capture in progress
//  errou_pulse     out  1  1-cycle pulse per wrong press or timeout
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all outputs 0, answer register 0, edge history 0.
//  Button press = rising edge of any botoes bit (registered previous value).
//  Press value = botoes sampled in the edge cycle.
//  States and transitions:
//   IDLE      -> MOVE on req_move; -> ESPERA on req_resposta.
//   MOVE      ocupado=1; counter increments.
//             At counter==MOVE_TICKS-1 -> PRONTO_MOV.
//   PRONTO_MOV  pronto_play=1 (level) until the next request; acertou_play=0.
//   ESPERA    ocupado=1; waits for a press.
//             press -> VERIFICA.
//             TIMEOUT!=0 and counter==TIMEOUT-1 -> ERROU.
//   VERIFICA  1 cycle.
//             press value == resposta_esp (exact 4-bit match) -> ACERTOU.
//             Otherwise -> ERROU. Multi-bit or zero value is always wrong.
//   ERROU     1 cycle: pronto_play=1, acertou_play=0, errou_pulse=1.
//             Counter cleared; -> ESPERA (player retries, expected answer kept).
//   ACERTOU   pronto_play=1 and acertou_play=1 held until the next request.
//  Requests:
//   - Either req pulse in any state (including mid-move or mid-capture) aborts
//     the current activity, clears the counter, and starts the new request next
//     cycle. pronto_play and acertou_play drop the cycle after the request.
//   - req_resposta and req_move in the same cycle: req_resposta wins.
//  Latency:
//   - Move: pronto_play high exactly MOVE_TICKS+1 cycles after the req_move cycle.
//   - Capture: press edge in cycle t -> pronto/acertou valid in cycle t+2.
//  Presses are ignored outside ESPERA. A button held across entry into ESPERA
//  does not count until it is released and pressed again.
//  Counter saturates; it never wraps.
// STRUCTURE
//  Shared package neurosync_pkg: state encodings (4-bit, matching the control
//  unit's encoding style), one-hot answer constants, default MOVE_TICKS.
//  Sub-module: neurosync_edge_detector (4-bit rising-edge detector, sync reset).
//  Single FSM plus one CNT_W counter; outputs decoded from state (Moore),
//  except errou_pulse, which is decoded from ERROU.
// TESTING
//  Bench uses MOVE_TICKS=8, TIMEOUT=0 unless noted.
//  1. req_move at t0 -> ocupado 1 for t1..t8; pronto_play=1 from t9 and held;
//     acertou_play=0.
//  2. req_resposta, resposta_esp=4'b0100; press 0100 at t -> t+2 pronto=1,
//     acertou=1, both held until next request.
//  3. Expected 0010; press 1000 -> single-cycle pronto=1, errou_pulse=1,
//     acertou=0; then press 0010 -> acertou=1, pronto=1 held.
//  4. Press 0110 (two buttons) against expected 0010 -> ERROU path;
//     button held from before the request -> no press registered.
//  5. req_move at t0; req_resposta at t4 -> move aborted, no pronto at t9,
//     ocupado stays 1; simultaneous req_move+req_resposta -> ESPERA.
//  6. TIMEOUT=5, no press -> errou_pulse every 6 cycles. Reset asserted
//     mid-ESPERA -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/neurosync_pkg.sv
// Shared encodings for the neurosync play handshake: FSM states, one-hot
// answer codes and default timing.
package neurosync_pkg;

    localparam int unsigned STATE_W            = 4;
    localparam int unsigned ANS_W              = 4;
    localparam int unsigned DEFAULT_MOVE_TICKS = 50_000_000;
    localparam int unsigned DEFAULT_CNT_W      = 26;

    localparam logic [ANS_W-1:0] ANS_BTN0 = 4'b0001;
    localparam logic [ANS_W-1:0] ANS_BTN1 = 4'b0010;
    localparam logic [ANS_W-1:0] ANS_BTN2 = 4'b0100;
    localparam logic [ANS_W-1:0] ANS_BTN3 = 4'b1000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 4'd0,
        ST_MOVE       = 4'd1,
        ST_PRONTO_MOV = 4'd2,
        ST_ESPERA     = 4'd3,
        ST_VERIFICA   = 4'd4,
        ST_ERROU      = 4'd5,
        ST_ACERTOU    = 4'd6
    } play_state_e;

    // True when exactly one bit of an answer code is set.
    function automatic logic is_onehot_ans(input logic [ANS_W-1:0] v);
        return (v != '0) && ((v & (v - ANS_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/neurosync_play_responder_if.sv
// Play handshake between the game control unit (master) and the responder
// (slave), plus the debounced buttons the responder watches.
interface neurosync_play_responder_if;
    import neurosync_pkg::*;

    logic             req_move;
    logic             req_resposta;
    logic [ANS_W-1:0] resposta_esp;
    logic [ANS_W-1:0] botoes;
    logic             pronto_play;
    logic             acertou_play;
    logic             ocupado;
    logic             errou_pulse;

    modport master (
        output req_move, req_resposta, resposta_esp, botoes,
        input  pronto_play, acertou_play, ocupado, errou_pulse
    );

    modport slave (
        input  req_move, req_resposta, resposta_esp, botoes,
        output pronto_play, acertou_play, ocupado, errou_pulse
    );
endinterface

// File: rtl/neurosync_edge_detector.sv
// Per-bit rising-edge detector; the edge flag is combinational on the
// current input against the registered previous value.
module neurosync_edge_detector #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_c_o
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_c_o = d_i & ~prev_q;

endmodule

// File: rtl/neurosync_play_responder.sv
// Responder for the play handshake: runs timed moves and answer captures,
// reporting completion and correctness back to the control unit.
module neurosync_play_responder
    import neurosync_pkg::*;
#(
    parameter int unsigned MOVE_TICKS = DEFAULT_MOVE_TICKS,
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
    input  logic                        clock,
    input  logic                        reset,
    neurosync_play_responder_if.slave   bus
);

    localparam logic [CNT_W-1:0] MOVE_LAST    = CNT_W'(MOVE_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);

    play_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ANS_W-1:0] resp_q, resp_d;
    logic [ANS_W-1:0] press_q, press_d;
    logic             pronto_q, pronto_d;
    logic             acertou_q, acertou_d;
    logic             ocupado_q, ocupado_d;
    logic             errou_q, errou_d;

    logic [ANS_W-1:0] rise_c;
    logic             press_c;

    neurosync_edge_detector #(.W(ANS_W)) u_edge (
        .clock    (clock),
        .reset    (reset),
        .d_i      (bus.botoes),
        .rise_c_o (rise_c)
    );

    assign press_c = |rise_c;

    // Next state, counter and captured values; requests override everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        press_d = press_q;

        unique case (state_q)
            ST_MOVE: begin
                if (cnt_q == MOVE_LAST) state_d = ST_PRONTO_MOV;
            end
            ST_ESPERA: begin
                if (press_c) begin
                    state_d = ST_VERIFICA;
                    press_d = bus.botoes;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    state_d = ST_ERROU;
                end
            end
            ST_VERIFICA: begin
                state_d = (is_onehot_ans(press_q) && (press_q == resp_q)) ? ST_ACERTOU : ST_ERROU;
            end
            ST_ERROU: begin
                state_d = ST_ESPERA;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (bus.req_resposta) begin
            state_d = ST_ESPERA;
            resp_d  = bus.resposta_esp;
        end else if (bus.req_move) begin
            state_d = ST_MOVE;
        end

        // Counter only runs while staying in a timed state, and saturates.
        if (bus.req_resposta || bus.req_move) begin
            cnt_d = '0;
        end else if (((state_q == ST_MOVE) || (state_q == ST_ESPERA)) && (state_d == state_q)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Moore outputs decoded from the upcoming state so they land in flops.
    always_comb begin
        pronto_d  = 1'b0;
        acertou_d = 1'b0;
        ocupado_d = 1'b0;
        errou_d   = 1'b0;
        unique case (state_d)
            ST_MOVE, ST_ESPERA: ocupado_d = 1'b1;
            ST_PRONTO_MOV:      pronto_d  = 1'b1;
            ST_ERROU: begin
                pronto_d = 1'b1;
                errou_d  = 1'b1;
            end
            ST_ACERTOU: begin
                pronto_d  = 1'b1;
                acertou_d = 1'b1;
            end
            default: begin
                pronto_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            resp_q    <= '0;
            press_q   <= '0;
            pronto_q  <= 1'b0;
            acertou_q <= 1'b0;
            ocupado_q <= 1'b0;
            errou_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            press_q   <= press_d;
            pronto_q  <= pronto_d;
            acertou_q <= acertou_d;
            ocupado_q <= ocupado_d;
            errou_q   <= errou_d;
        end
    end

    assign bus.pronto_play  = pronto_q;
    assign bus.acertou_play = acertou_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.errou_pulse  = errou_q;

endmodule

// File: tb/tb_neurosync_play_responder.sv
// Directed bench for neurosync_play_responder: MOVE_TICKS=8 without timeout,
// plus a second instance with TIMEOUT=5. Outputs packed as {ocupado,pronto,acertou,errou}.
module tb_neurosync_play_responder;
    import neurosync_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    neurosync_play_responder_if bus ();
    neurosync_play_responder_if bus_t ();

    neurosync_play_responder #(.MOVE_TICKS(8), .TIMEOUT(0), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    neurosync_play_responder #(.MOVE_TICKS(8), .TIMEOUT(5), .CNT_W(8)) dut_t (
        .clock (clock),
        .reset (reset),
        .bus   (bus_t)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {bus.ocupado, bus.pronto_play, bus.acertou_play, bus.errou_pulse};
    endfunction

    function automatic logic [3:0] obs_t();
        return {bus_t.ocupado, bus_t.pronto_play, bus_t.acertou_play, bus_t.errou_pulse};
    endfunction

    task automatic test_reset();
        logic [3:0] o;
        reset = 1'b1;
        bus.req_move = 1'b0;   bus.req_resposta = 1'b0;   bus.resposta_esp = '0;   bus.botoes = '0;
        bus_t.req_move = 1'b0; bus_t.req_resposta = 1'b0; bus_t.resposta_esp = '0; bus_t.botoes = '0;
        repeat (3) cyc();
        o = obs();
        vectors++;
        if (o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=0000", o);
        end
        vectors++;
        if (dut.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
        end
        reset = 1'b0;
        cyc();
        o = obs();
        vectors++;
        if (o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_idle got=%b exp=0000", o);
        end
    endtask

    task automatic test_move();
        logic [3:0] o, e;
        bus.req_move = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            cyc();
            bus.req_move = 1'b0;
            o = obs();
            e = (t <= 8) ? 4'b1000 : 4'b0100;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL move t=%0d got=%b exp=%b", t, o, e);
            end
        end
    endtask

    task automatic test_correct();
        logic [3:0] o, e;
        bus.req_resposta = 1'b1;
        bus.resposta_esp = ANS_BTN2;
        for (int t = 1; t <= 8; t++) begin
            cyc();
            bus.req_resposta = 1'b0;
            o = obs();
            e = (t <= 3) ? 4'b1000 : 4'b0110;
            if (t != 4) begin
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL correct t=%0d got=%b exp=%b", t, o, e);
                end
            end
            if (t == 3) bus.botoes = 4'b0100;
            if (t == 7) bus.botoes = 4'b0000;
        end
    endtask

    task automatic test_wrong_retry();
        logic [3:0] o, e;
        bus.req_resposta = 1'b1;
        bus.resposta_esp = ANS_BTN1;
        for (int t = 1; t <= 7; t++) begin
            cyc();
            bus.req_resposta = 1'b0;
            o = obs();
            case (t)
                3:       e = 4'b0101;
                6, 7:    e = 4'b0110;
                default: e = 4'b1000;
            endcase
            if (t != 2 && t != 5) begin
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL wrong_retry t=%0d got=%b exp=%b", t, o, e);
                end
            end
            case (t)
                1:       bus.botoes = 4'b1000;
                4:       bus.botoes = 4'b0010;
                default: bus.botoes = 4'b0000;
            endcase
        end
    endtask

    task automatic test_multi_held();
        logic [3:0] o, e;
        bus.botoes = 4'b0001;
        cyc();
        bus.req_resposta = 1'b1;
        bus.resposta_esp = ANS_BTN1;
        for (int t = 1; t <= 8; t++) begin
            cyc();
            bus.req_resposta = 1'b0;
            o = obs();
            e = (t == 7) ? 4'b0101 : 4'b1000;
            if (t != 6) begin
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL multi_held t=%0d got=%b exp=%b", t, o, e);
                end
            end
            if (t == 4) bus.botoes = 4'b0000;
            if (t == 5) bus.botoes = 4'b0110;
            if (t == 6) bus.botoes = 4'b0000;
        end
    endtask

    task automatic test_restart();
        logic [3:0] o, e;
        bus.req_move = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            cyc();
            bus.req_move = 1'b0;
            o = obs();
            e = (t <= 13) ? 4'b1000 : 4'b0100;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL restart t=%0d got=%b exp=%b", t, o, e);
            end
            if (t == 5) bus.req_move = 1'b1;
        end
    endtask

    task automatic test_abort();
        logic [3:0] o, e;
        bus.req_move = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            cyc();
            bus.req_move     = 1'b0;
            bus.req_resposta = 1'b0;
            o = obs();
            e = (t == 22) ? 4'b0110 : 4'b1000;
            if (t != 21) begin
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL abort t=%0d got=%b exp=%b", t, o, e);
                end
            end
            if (t == 4) begin
                bus.req_resposta = 1'b1;
                bus.resposta_esp = ANS_BTN0;
            end
            if (t == 10) begin
                bus.req_move     = 1'b1;
                bus.req_resposta = 1'b1;
                bus.resposta_esp = ANS_BTN3;
            end
            if (t == 20) bus.botoes = 4'b1000;
            if (t == 21) bus.botoes = 4'b0000;
        end
    endtask

    task automatic test_timeout_reset();
        logic [3:0] o, e;
        bus_t.req_resposta = 1'b1;
        bus_t.resposta_esp = ANS_BTN0;
        for (int t = 1; t <= 19; t++) begin
            cyc();
            bus_t.req_resposta = 1'b0;
            o = obs_t();
            e = (t == 6 || t == 12 || t == 18) ? 4'b0101 : 4'b1000;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL timeout t=%0d got=%b exp=%b", t, o, e);
            end
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        o = obs_t();
        vectors++;
        if (o !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got=%b exp=0000", o);
        end
        o = obs();
        vectors++;
        if (o !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_outputs_main got=%b exp=0000", o);
        end
        vectors++;
        if (dut_t.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL mid_reset_state got=%0d exp=%0d", dut_t.state_q, ST_IDLE);
        end
        for (int t = 1; t <= 8; t++) begin
            cyc();
            o = obs_t();
            vectors++;
            if (o !== 4'b0000) begin
                miscompares++;
                $display("FAIL post_reset_idle t=%0d got=%b exp=0000", t, o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_correct();
        test_wrong_retry();
        test_multi_held();
        test_restart();
        test_abort();
        test_timeout_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
